// File: rtl/vco_meas_pkg.sv
// Shared definitions for the VCO gated frequency meter: FSM states and default widths.
package vco_meas_pkg;

    localparam int DEFAULT_GATE_W = 16;
    localparam int DEFAULT_CNT_W  = 20;
    localparam int unsigned CNT_MAX = (1 << DEFAULT_CNT_W) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } meas_state_e;

endpackage

// File: rtl/vco_edge_sync.sv
// Brings the divided VCO output into the CLK domain and emits a one-cycle pulse per rising edge.
// All asynchronous-crossing flops of the meter live here and nowhere else.
module vco_edge_sync
    import vco_meas_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic vco_in,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic hist;

    // NOTE: non-blocking assignments make every flop sample its pre-edge input,
    // so the chain really is three stages; blocking here would collapse it into one.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            hist   <= 1'b0;
        end else begin
            sync_1 <= vco_in;
            sync_2 <= sync_1;
            hist   <= sync_2;
        end
    end

    assign rise = sync_2 & ~hist;

endmodule

// File: rtl/vco_freq_meter.sv
// Gated frequency counter: counts synchronised VCO rising edges over a window of
// GATE_CYCLES clocks and presents the result with a level VALID/ACK handshake.
module vco_freq_meter
    import vco_meas_pkg::*;
#(
    parameter int GATE_W = DEFAULT_GATE_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              VCO_IN,
    input  logic              MEAS_TRIG,
    input  logic [GATE_W-1:0] GATE_CYCLES,
    input  logic              ABORT,
    input  logic              ACK,
    output logic [CNT_W-1:0]  BF_COUNT,
    output logic              VALID,
    output logic              BUSY,
    output logic              OVERFLOW
);

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    meas_state_e       state;
    meas_state_e       state_next;
    logic [GATE_W-1:0] gate_left;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              ovf;
    logic              ovf_next;
    logic [CNT_W-1:0]  bf_count_r;
    logic              valid_r;
    logic              overflow_r;
    logic              rise;
    logic              accept;
    logic              load_result;
    logic              zero_gate;

    vco_edge_sync u_edge_sync (
        .clk    (CLK),
        .reset  (RESET),
        .vco_in (VCO_IN),
        .rise   (rise)
    );

    assign zero_gate = (GATE_CYCLES == '0);

    // Saturating edge counter; the value includes the current cycle's edge so the
    // last window cycle can be loaded straight into the result register.
    always_comb begin
        cnt_next = cnt;
        ovf_next = ovf;
        if (rise) begin
            if (cnt == CNT_SAT) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        load_result = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (MEAS_TRIG) begin
                    accept = 1'b1;
                    if (zero_gate) begin
                        state_next  = DONE;
                        load_result = 1'b1;
                    end else begin
                        state_next = COUNT;
                    end
                end
            end
            COUNT: begin
                // ABORT outranks the closing cycle, so an aborted window never loads.
                if (ABORT) begin
                    state_next = IDLE;
                end else if (gate_left == GATE_W'(1)) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            gate_left  <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            bf_count_r <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (accept) begin
                gate_left <= GATE_CYCLES;
                cnt       <= '0;
                ovf       <= 1'b0;
            end else if (state == COUNT) begin
                gate_left <= gate_left - GATE_W'(1);
                cnt       <= cnt_next;
                ovf       <= ovf_next;
            end

            // A zero-length window completes on the trigger itself with a zero result.
            if (load_result) begin
                bf_count_r <= accept ? '0 : cnt_next;
                overflow_r <= accept ? 1'b0 : ovf_next;
                valid_r    <= 1'b1;
            end else if (accept || ACK) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign BF_COUNT = bf_count_r;
    assign VALID    = valid_r;
    assign BUSY     = (state == COUNT);
    assign OVERFLOW = overflow_r;

endmodule

// File: tb/tb_vco_freq_meter.sv
// Scoreboard bench for vco_freq_meter: a default-width instance plus a CNT_W=4 instance
// sharing all inputs; expectations are queued at trigger time and retired on VALID.
module tb_vco_freq_meter;

    typedef struct {
        int n;
        int lo;
        int hi;
        bit ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        meas_trig = 1'b0;
    logic [15:0] gate_cycles = '0;
    logic        abort_m = 1'b0;
    logic        ack = 1'b0;

    logic        vco_gen = 1'b0;
    logic        vco_man = 1'b0;
    int          vco_half = 0;
    logic        vco_in;

    logic [19:0] bf_count;
    logic        valid;
    logic        busy;
    logic        overflow;
    logic [3:0]  bf_count_s;
    logic        valid_s;
    logic        busy_s;
    logic        overflow_s;

    bit          sel = 1'b0;
    logic [19:0] o_count;
    logic        o_valid;
    logic        o_busy;
    logic        o_ovf;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;

    assign vco_in  = (vco_half == 0) ? vco_man : vco_gen;
    assign o_count = sel ? {16'd0, bf_count_s} : bf_count;
    assign o_valid = sel ? valid_s : valid;
    assign o_busy  = sel ? busy_s : busy;
    assign o_ovf   = sel ? overflow_s : overflow;

    vco_freq_meter dut (
        .CLK         (clk),
        .RESET       (reset),
        .VCO_IN      (vco_in),
        .MEAS_TRIG   (meas_trig),
        .GATE_CYCLES (gate_cycles),
        .ABORT       (abort_m),
        .ACK         (ack),
        .BF_COUNT    (bf_count),
        .VALID       (valid),
        .BUSY        (busy),
        .OVERFLOW    (overflow)
    );

    vco_freq_meter #(.GATE_W(16), .CNT_W(4)) dut_small (
        .CLK         (clk),
        .RESET       (reset),
        .VCO_IN      (vco_in),
        .MEAS_TRIG   (meas_trig),
        .GATE_CYCLES (gate_cycles),
        .ABORT       (abort_m),
        .ACK         (ack),
        .BF_COUNT    (bf_count_s),
        .VALID       (valid_s),
        .BUSY        (busy_s),
        .OVERFLOW    (overflow_s)
    );

    always #5 clk = ~clk;

    // Free-running VCO model: half period in CLK cycles, disabled when zero.
    always begin
        if (vco_half == 0) begin
            @(vco_half);
        end else begin
            #(vco_half * 10);
            vco_gen = ~vco_gen;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Trigger one window and retire its scoreboard entry when VALID appears.
    task automatic run_meas(input int n, input int lo, input int hi, input bit ovf,
                            input int retrig_at, input bit with_ack);
        exp_t e;
        int   k;
        int   busy_cnt;
        int   cnt_obs;
        int   clamp;
        bit   done;
        e.n = n;
        e.lo = lo;
        e.hi = hi;
        e.ovf = ovf;
        sb.push_back(e);
        meas_trig   = 1'b1;
        gate_cycles = n[15:0];
        ack         = with_ack;
        tick;
        meas_trig = 1'b0;
        ack       = 1'b0;
        if (with_ack) check("trig_ack_valid_clr", {31'd0, o_valid}, 32'd0);
        k = 1;
        busy_cnt = 0;
        done = 1'b0;
        while (!done && k <= n + 20) begin
            if (o_valid) begin
                done = 1'b1;
            end else begin
                busy_cnt += int'(o_busy);
                if (k == retrig_at) meas_trig = 1'b1;
                tick;
                meas_trig = 1'b0;
                k++;
            end
        end
        e = sb.pop_front();
        if (!done) begin
            check("valid_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", k, e.n + 1);
        check("busy_cycles", busy_cnt, e.n);
        cnt_obs = int'(o_count);
        clamp = (cnt_obs < e.lo) ? e.lo : ((cnt_obs > e.hi) ? e.hi : cnt_obs);
        check("bf_count", cnt_obs, clamp);
        check("overflow", {31'd0, o_ovf}, {31'd0, e.ovf});
    endtask

    initial begin
        repeat (3) tick;
        check("rst_bf_count", {12'd0, bf_count}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        repeat (3) tick;

        // Zero-length window: result 0 one cycle after the trigger, BUSY never high.
        run_meas(0, 0, 0, 1'b0, 0, 1'b0);

        // Two hand-placed edges well inside a 30-cycle window give an exact count.
        fork
            begin
                repeat (5) tick;
                vco_man = 1'b1;
                repeat (3) tick;
                vco_man = 1'b0;
                repeat (7) tick;
                vco_man = 1'b1;
                repeat (3) tick;
                vco_man = 1'b0;
            end
        join_none
        run_meas(30, 2, 2, 1'b0, 0, 1'b0);

        ack = 1'b1;
        tick;
        ack = 1'b0;
        check("ack_valid_clr", {31'd0, valid}, 32'd0);
        check("ack_bf_held", {12'd0, bf_count}, 32'd2);

        // Abort on window cycle 3 of 5.
        meas_trig   = 1'b1;
        gate_cycles = 16'd5;
        tick;
        meas_trig = 1'b0;
        check("abort3_busy_open", {31'd0, busy}, 32'd1);
        repeat (2) tick;
        abort_m = 1'b1;
        tick;
        abort_m = 1'b0;
        check("abort3_busy", {31'd0, busy}, 32'd0);
        check("abort3_valid", {31'd0, valid}, 32'd0);
        check("abort3_bf_held", {12'd0, bf_count}, 32'd2);
        repeat (10) tick;
        check("abort3_no_late_valid", {31'd0, valid}, 32'd0);

        // Abort coinciding with the last window cycle.
        meas_trig   = 1'b1;
        gate_cycles = 16'd5;
        tick;
        meas_trig = 1'b0;
        repeat (4) tick;
        abort_m = 1'b1;
        tick;
        abort_m = 1'b0;
        check("abort_last_valid", {31'd0, valid}, 32'd0);
        check("abort_last_busy", {31'd0, busy}, 32'd0);
        check("abort_last_bf_held", {12'd0, bf_count}, 32'd2);

        // Period 10 VCO.
        vco_half = 5;
        repeat (10) tick;
        run_meas(1000, 99, 101, 1'b0, 0, 1'b0);
        run_meas(100, 9, 11, 1'b0, 50, 1'b0);
        run_meas(50, 4, 6, 1'b0, 0, 1'b1);

        // Period 4 VCO against the 4-bit counter: saturation, then a clean run.
        vco_half = 2;
        sel = 1'b1;
        repeat (8) tick;
        run_meas(200, 15, 15, 1'b1, 0, 1'b0);
        run_meas(20, 4, 6, 1'b0, 0, 1'b0);
        sel = 1'b0;

        // Reset mid-window with the VCO toggling.
        vco_half = 5;
        meas_trig   = 1'b1;
        gate_cycles = 16'd100;
        tick;
        meas_trig = 1'b0;
        repeat (19) tick;
        reset = 1'b1;
        tick;
        check("midrst_bf_count", {12'd0, bf_count}, 32'd0);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
        check("midrst_small_bf_count", {28'd0, bf_count_s}, 32'd0);
        check("midrst_small_valid", {31'd0, valid_s}, 32'd0);

        // Static-high VCO after reset must count nothing.
        vco_half = 0;
        vco_man  = 1'b1;
        repeat (2) tick;
        reset = 1'b0;
        repeat (8) tick;
        run_meas(50, 0, 0, 1'b0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
